// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, flag bit positions and JMP condition codes.
// Used by the controller, the decoder and the register-file/flag unit.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int REG_AW = 2;

    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        JC_ALWAYS = 2'b00,
        JC_C      = 2'b01,
        JC_Z      = 2'b10,
        JC_N      = 2'b11
    } jmp_cond_e;

endpackage

// File: rtl/czn_flags.sv
// C/Z/N flag register with ALU/RF source selection and jump-condition evaluation.
// The jump decision uses only registered flags, so a new flag value never affects the cycle that loads it.
module czn_flags #(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_CZN,
    input  logic              sel_CZN_src_ALU,
    input  logic              sel_CZN_src_RF,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_c,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        jmp_cond,
    output logic [2:0]        flags,
    output logic              out_jump_sel
);
    import cpu_pkg::FLAG_C;
    import cpu_pkg::FLAG_Z;
    import cpu_pkg::FLAG_N;
    import cpu_pkg::jmp_cond_e;
    import cpu_pkg::JC_ALWAYS;
    import cpu_pkg::JC_C;
    import cpu_pkg::JC_Z;
    import cpu_pkg::JC_N;

    // NOTE: state is written with <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= 3'b000;
        end else if (ld_CZN) begin
            if (sel_CZN_src_ALU) begin
                flags[FLAG_C] <= alu_c;
                flags[FLAG_Z] <= (alu_result == '0);
                flags[FLAG_N] <= alu_result[DATA_W-1];
            end else if (sel_CZN_src_RF) begin
                // Register moves/loads carry no carry information, so C is left alone.
                flags[FLAG_Z] <= (wr_data == '0);
                flags[FLAG_N] <= wr_data[DATA_W-1];
            end
        end
    end

    // NOTE: the default assignment ahead of the case keeps this block purely combinational (no latch).
    always_comb begin
        out_jump_sel = 1'b1;
        unique case (jmp_cond_e'(jmp_cond))
            JC_ALWAYS: out_jump_sel = 1'b1;
            JC_C:      out_jump_sel = flags[FLAG_C];
            JC_Z:      out_jump_sel = flags[FLAG_Z];
            JC_N:      out_jump_sel = flags[FLAG_N];
        endcase
    end

endmodule

// File: rtl/rf_flags.sv
// Register file (one write port, two combinational read ports, no bypass) plus the CZN flag unit.
// Sits between the controller and the ALU/memory muxes of the multicycle 8-bit CPU.
module rf_flags #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int NREG   = 4,
    parameter int REG_AW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en_rf,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] rd_addr1,
    input  logic [REG_AW-1:0] rd_addr2,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    input  logic              ld_CZN,
    input  logic              sel_CZN_src_ALU,
    input  logic              sel_CZN_src_RF,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_c,
    input  logic [1:0]        jmp_cond,
    output logic [2:0]        flags,
    output logic              out_jump_sel
);

    logic [DATA_W-1:0] regs [NREG];

    // NOTE: the array is reset, which forces it into flops; this is intended for a 4-entry file
    // that must read zero after reset, and would be wrong for anything meant to map to RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en_rf) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign reg1 = regs[rd_addr1];
    assign reg2 = regs[rd_addr2];

    czn_flags #(
        .DATA_W (DATA_W)
    ) u_czn_flags (
        .clk             (clk),
        .rst             (rst),
        .ld_CZN          (ld_CZN),
        .sel_CZN_src_ALU (sel_CZN_src_ALU),
        .sel_CZN_src_RF  (sel_CZN_src_RF),
        .alu_result      (alu_result),
        .alu_c           (alu_c),
        .wr_data         (wr_data),
        .jmp_cond        (jmp_cond),
        .flags           (flags),
        .out_jump_sel    (out_jump_sel)
    );

endmodule

// File: tb/tb_rf_flags.sv
// Directed, table-driven bench for rf_flags: each row drives one cycle and checks the pre-edge outputs.
// Hand-written sequences cover reset state and reset asserted during a write/flag load.
module tb_rf_flags;

    logic       clk = 1'b0;
    logic       rst;
    logic       write_en_rf;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] rd_addr1, rd_addr2;
    logic [7:0] reg1, reg2;
    logic       ld_CZN, sel_CZN_src_ALU, sel_CZN_src_RF;
    logic [7:0] alu_result;
    logic       alu_c;
    logic [1:0] jmp_cond;
    logic [2:0] flags;
    logic       out_jump_sel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_flags dut (
        .clk             (clk),
        .rst             (rst),
        .write_en_rf     (write_en_rf),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .rd_addr1        (rd_addr1),
        .rd_addr2        (rd_addr2),
        .reg1            (reg1),
        .reg2            (reg2),
        .ld_CZN          (ld_CZN),
        .sel_CZN_src_ALU (sel_CZN_src_ALU),
        .sel_CZN_src_RF  (sel_CZN_src_RF),
        .alu_result      (alu_result),
        .alu_c           (alu_c),
        .jmp_cond        (jmp_cond),
        .flags           (flags),
        .out_jump_sel    (out_jump_sel)
    );

    typedef struct {
        logic       we;
        logic [1:0] wa;
        logic [7:0] wd;
        logic [1:0] ra1;
        logic [1:0] ra2;
        logic       ld;
        logic       sa;
        logic       sr;
        logic [7:0] ar;
        logic       ac;
        logic [1:0] jc;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [2:0] ef;
        logic       ej;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic we, logic [1:0] wa, logic [7:0] wd, logic [1:0] ra1, logic [1:0] ra2,
                                logic ld, logic sa, logic sr, logic [7:0] ar, logic ac, logic [1:0] jc,
                                logic [7:0] e1, logic [7:0] e2, logic [2:0] ef, logic ej);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ra1 = ra1; v.ra2 = ra2;
        v.ld = ld; v.sa = sa; v.sr = sr; v.ar = ar; v.ac = ac; v.jc = jc;
        v.e1 = e1; v.e2 = e2; v.ef = ef; v.ej = ej;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        write_en_rf = 1'b0; wr_addr = 2'd0; wr_data = 8'h00;
        rd_addr1 = 2'd0; rd_addr2 = 2'd0;
        ld_CZN = 1'b0; sel_CZN_src_ALU = 1'b0; sel_CZN_src_RF = 1'b0;
        alu_result = 8'h00; alu_c = 1'b0; jmp_cond = 2'd0;
    endtask

    // Reads all four registers and all four jump conditions, expecting the cleared state.
    task automatic check_cleared(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd_addr1 = 2'(i);
            rd_addr2 = 2'(3 - i);
            #1;
            check($sformatf("%s reg1[r%0d]", tag, i), 32'(reg1), 32'h00);
            check($sformatf("%s reg2[r%0d]", tag, 3 - i), 32'(reg2), 32'h00);
        end
        check({tag, " flags"}, 32'(flags), 32'b000);
        for (int j = 0; j < 4; j++) begin
            jmp_cond = 2'(j);
            #0.1;
            check($sformatf("%s jump jc=%0d", tag, j), 32'(out_jump_sel), (j == 0) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //           we wa  wd     ra1 ra2 ld sa sr ar     ac jc     e1     e2     ef      ej
        vecs[0]  = mk(1, 2, 8'hA5, 2, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 3'b000, 1); // write r2, old value seen
        vecs[1]  = mk(0, 0, 8'h00, 2, 1, 0, 0, 0, 8'h00, 0, 1, 8'hA5, 8'h00, 3'b000, 0);
        vecs[2]  = mk(0, 0, 8'h00, 0, 3, 1, 1, 0, 8'h00, 1, 2, 8'h00, 8'h00, 3'b000, 0); // ALU load, not yet visible
        vecs[3]  = mk(0, 0, 8'h00, 2, 3, 0, 0, 0, 8'h00, 0, 1, 8'hA5, 8'h00, 3'b110, 1);
        vecs[4]  = mk(0, 0, 8'h00, 2, 0, 0, 0, 0, 8'h00, 0, 2, 8'hA5, 8'h00, 3'b110, 1);
        vecs[5]  = mk(0, 0, 8'h00, 1, 2, 0, 0, 0, 8'h00, 0, 3, 8'h00, 8'hA5, 3'b110, 0);
        vecs[6]  = mk(1, 1, 8'h80, 1, 2, 1, 0, 1, 8'h00, 0, 0, 8'h00, 8'hA5, 3'b110, 1); // RF load + write, C held
        vecs[7]  = mk(0, 0, 8'h00, 1, 3, 0, 0, 0, 8'h00, 0, 3, 8'h80, 8'h00, 3'b101, 1);
        vecs[8]  = mk(0, 0, 8'h00, 1, 2, 1, 1, 1, 8'h01, 0, 1, 8'h80, 8'hA5, 3'b101, 1); // both selects: ALU wins
        vecs[9]  = mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 1, 2, 8'h00, 8'h00, 3'b000, 0); // ld=0: hold
        vecs[10] = mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 8'h00, 0, 2, 8'h00, 8'h00, 3'b000, 0);
        vecs[11] = mk(0, 0, 8'h00, 0, 0, 1, 1, 0, 8'hFF, 0, 3, 8'h00, 8'h00, 3'b000, 0);
        vecs[12] = mk(1, 3, 8'h3C, 3, 2, 0, 0, 0, 8'h00, 0, 3, 8'h00, 8'hA5, 3'b001, 1);
        vecs[13] = mk(0, 0, 8'h00, 3, 0, 1, 0, 1, 8'h00, 0, 0, 8'h3C, 8'h00, 3'b001, 1); // RF load of zero, no write
        vecs[14] = mk(1, 0, 8'h11, 3, 1, 0, 0, 0, 8'h00, 0, 2, 8'h3C, 8'h80, 3'b010, 1);
        vecs[15] = mk(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 1, 8'h11, 8'h80, 3'b010, 0);

        idle_inputs();
        rst = 1'b1;
        #1;
        check_cleared("reset");
        @(negedge clk);
        rst = 1'b0;
        jmp_cond = 2'd0;

        for (int k = 0; k < NVEC; k++) begin
            @(negedge clk);
            write_en_rf = vecs[k].we; wr_addr = vecs[k].wa; wr_data = vecs[k].wd;
            rd_addr1 = vecs[k].ra1; rd_addr2 = vecs[k].ra2;
            ld_CZN = vecs[k].ld; sel_CZN_src_ALU = vecs[k].sa; sel_CZN_src_RF = vecs[k].sr;
            alu_result = vecs[k].ar; alu_c = vecs[k].ac; jmp_cond = vecs[k].jc;
            #2;
            check($sformatf("vec%0d reg1", k), 32'(reg1), 32'(vecs[k].e1));
            check($sformatf("vec%0d reg2", k), 32'(reg2), 32'(vecs[k].e2));
            check($sformatf("vec%0d flags", k), 32'(flags), 32'(vecs[k].ef));
            check($sformatf("vec%0d jump", k), 32'(out_jump_sel), 32'(vecs[k].ej));
        end

        // Reset asserted mid-cycle while a write and a flag load are pending.
        @(negedge clk);
        write_en_rf = 1'b1; wr_addr = 2'd2; wr_data = 8'hFF;
        ld_CZN = 1'b1; sel_CZN_src_ALU = 1'b1; alu_result = 8'h80; alu_c = 1'b1;
        rd_addr1 = 2'd0; rd_addr2 = 2'd1;
        #1;
        rst = 1'b1;
        #0.5;
        check_cleared("rst-async");
        @(posedge clk);
        #1;
        check_cleared("rst-edge");
        @(negedge clk);
        rst = 1'b0;
        write_en_rf = 1'b0; ld_CZN = 1'b0; sel_CZN_src_ALU = 1'b0;
        #1;
        check_cleared("rst-release");
        @(posedge clk);
        #1;
        check_cleared("post-release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
